// File: rtl/flash_sample_streamer.sv
// Flash-backed audio sample streamer.
// Fetches one 32-bit flash word at a time over Avalon-MM and hands out 8- or 16-bit
// samples on each sample_req strobe. It plays forward or in reverse through a bounded
// word region, and either loops or stops at the clip end.
module flash_sample_streamer #(
  parameter int unsigned BASE       = 0,
  parameter int unsigned MAX_OFFSET = 16'h7FFF,
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned SAMPLE_W   = 8,
  parameter int unsigned LOOP       = 1
) (
  input  logic                fetch_clock,
  input  logic                reset,
  input  logic                flash_mem_waitrequest,
  input  logic [31:0]         flash_mem_readdata,
  input  logic                flash_mem_readdatavalid,
  output logic                flash_mem_read,
  output logic [ADDR_W-1:0]   flash_mem_address,
  input  logic                start,
  input  logic                pause,
  input  logic                reverse,
  input  logic                sample_req,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                underrun,
  output logic                busy,
  output logic                done
);

  localparam int unsigned SPW  = 32 / SAMPLE_W;
  localparam int unsigned IdxW = $clog2(SPW);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BASE + MAX_OFFSET);
  localparam logic [IdxW-1:0]   IdxLast  = IdxW'(SPW - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWaitData, StServe} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     word_addr_q, word_addr_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [31:0]           buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic [SAMPLE_W-1:0]   sample_out_q, sample_out_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  done_q, done_d;
  // A read was abandoned while still in flight; its data beat must be swallowed.
  logic                  discard_q, discard_d;

  logic                  read_accept;
  logic                  drop_pending;
  logic                  req_live;
  logic                  word_last;
  logic                  clip_end;
  logic [31:0]           shifted;
  logic [SAMPLE_W-1:0]   cur_sample;

  // No new read is issued until an abandoned one has delivered its data, so at most
  // one read is ever outstanding.
  assign flash_mem_read    = (state_q == StReq) && !discard_q;
  assign flash_mem_address = word_addr_q;
  assign read_accept       = flash_mem_read && !flash_mem_waitrequest;

  // An abort leaves a data beat still to come if a read is accepted this cycle, we are
  // waiting on data that has not arrived, or an older abandoned beat is still due.
  assign drop_pending = read_accept
                     || ((state_q == StWaitData) && !flash_mem_readdatavalid)
                     || (discard_q && !flash_mem_readdatavalid);

  assign req_live   = sample_req && !pause;
  assign word_last  = reverse ? (idx_q == '0) : (idx_q == IdxLast);
  assign clip_end   = reverse ? (word_addr_q == BaseAddr) : (word_addr_q == LastAddr);
  assign shifted    = buf_q >> (32'(idx_q) * 32'(SAMPLE_W));
  assign cur_sample = shifted[SAMPLE_W-1:0];

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign underrun     = underrun_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;

  // Next-state logic: start overrides everything, otherwise the per-state behaviour.
  always_comb begin
    state_d        = state_q;
    word_addr_d    = word_addr_q;
    idx_d          = idx_q;
    buf_d          = buf_q;
    buf_full_d     = buf_full_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    underrun_d     = 1'b0;
    done_d         = done_q;
    discard_d      = discard_q;

    if (discard_q && flash_mem_readdatavalid) begin
      discard_d = 1'b0;
    end

    if (start) begin
      state_d     = StReq;
      word_addr_d = reverse ? LastAddr : BaseAddr;
      idx_d       = reverse ? IdxLast : '0;
      buf_full_d  = 1'b0;
      done_d      = 1'b0;
      discard_d   = drop_pending;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StReq: begin
          if (req_live) begin
            underrun_d = 1'b1;
          end
          if (read_accept) begin
            state_d = StWaitData;
          end
        end
        StWaitData: begin
          if (req_live) begin
            underrun_d = 1'b1;
          end
          if (flash_mem_readdatavalid) begin
            buf_d      = flash_mem_readdata;
            buf_full_d = 1'b1;
            state_d    = StServe;
          end
        end
        StServe: begin
          if (req_live && buf_full_q) begin
            sample_out_d   = cur_sample;
            sample_valid_d = 1'b1;
            if (!word_last) begin
              idx_d = reverse ? (idx_q - IdxW'(1)) : (idx_q + IdxW'(1));
            end else begin
              buf_full_d = 1'b0;
              idx_d      = reverse ? IdxLast : '0;
              if (!clip_end) begin
                word_addr_d = reverse ? (word_addr_q - ADDR_W'(1))
                                      : (word_addr_q + ADDR_W'(1));
                state_d     = StReq;
              end else if (LOOP != 0) begin
                word_addr_d = reverse ? LastAddr : BaseAddr;
                state_d     = StReq;
              end else begin
                state_d = StIdle;
                done_d  = 1'b1;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State register with synchronous reset; reset still remembers an in-flight read.
  always_ff @(posedge fetch_clock) begin
    if (reset) begin
      state_q        <= StIdle;
      word_addr_q    <= BaseAddr;
      idx_q          <= '0;
      buf_q          <= '0;
      buf_full_q     <= 1'b0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
      done_q         <= 1'b0;
      discard_q      <= drop_pending;
    end else begin
      state_q        <= state_d;
      word_addr_q    <= word_addr_d;
      idx_q          <= idx_d;
      buf_q          <= buf_d;
      buf_full_q     <= buf_full_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      underrun_q     <= underrun_d;
      done_q         <= done_d;
      discard_q      <= discard_d;
    end
  end

endmodule

// File: tb/tb_flash_sample_streamer.sv
// Directed bench for flash_sample_streamer: an 8-bit looping instance and a 16-bit
// one-shot instance, each fed by a small zero-wait flash model.
module tb_flash_sample_streamer;

  localparam logic [31:0] W0 = 32'h4433_2211;
  localparam logic [31:0] W1 = 32'h8877_6655;
  localparam logic [31:0] W16 = 32'hBBBB_AAAA;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // 8-bit looping instance
  logic        wait8 = 1'b0, mute8 = 1'b0, inj8 = 1'b0;
  logic [31:0] rdata8 = '0;
  logic        mrdv8 = 1'b0, rdv8, rd8;
  logic [22:0] addr8;
  logic        start8 = 1'b0, pause8 = 1'b0, rev8 = 1'b0, req8 = 1'b0;
  logic [7:0]  out8;
  logic        valid8, under8, busy8, done8;

  // 16-bit one-shot instance
  logic        mrdv16 = 1'b0, rd16;
  logic [31:0] rdata16 = '0;
  logic [22:0] addr16;
  logic        start16 = 1'b0, req16 = 1'b0;
  logic [15:0] out16;
  logic        valid16, under16, busy16, done16;

  int compared = 0;
  int mismatched = 0;

  assign rdv8 = mrdv8 | inj8;

  always #5 clk = ~clk;

  flash_sample_streamer #(
    .BASE(0), .MAX_OFFSET(1), .ADDR_W(23), .SAMPLE_W(8), .LOOP(1)
  ) dut8 (
    .fetch_clock(clk), .reset(rst),
    .flash_mem_waitrequest(wait8), .flash_mem_readdata(rdata8),
    .flash_mem_readdatavalid(rdv8), .flash_mem_read(rd8), .flash_mem_address(addr8),
    .start(start8), .pause(pause8), .reverse(rev8), .sample_req(req8),
    .sample_out(out8), .sample_valid(valid8), .underrun(under8),
    .busy(busy8), .done(done8)
  );

  flash_sample_streamer #(
    .BASE(0), .MAX_OFFSET(0), .ADDR_W(23), .SAMPLE_W(16), .LOOP(0)
  ) dut16 (
    .fetch_clock(clk), .reset(rst),
    .flash_mem_waitrequest(1'b0), .flash_mem_readdata(rdata16),
    .flash_mem_readdatavalid(mrdv16), .flash_mem_read(rd16), .flash_mem_address(addr16),
    .start(start16), .pause(1'b0), .reverse(1'b0), .sample_req(req16),
    .sample_out(out16), .sample_valid(valid16), .underrun(under16),
    .busy(busy16), .done(done16)
  );

  // Flash models: data one cycle after an accepted read.
  always @(posedge clk) begin
    mrdv8 <= 1'b0;
    if (rd8 && !wait8 && !mute8) begin
      mrdv8  <= 1'b1;
      rdata8 <= (addr8 == 23'd1) ? W1 : W0;
    end
    mrdv16 <= 1'b0;
    if (rd16) begin
      mrdv16  <= 1'b1;
      rdata16 <= (addr16 == 23'd0) ? W16 : 32'hDEAD_BEEF;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe8(input string tag, input logic [7:0] exp);
    req8 = 1'b1;
    step();
    req8 = 1'b0;
    check({tag, ".valid"}, {31'd0, valid8}, 32'd1);
    check({tag, ".data"}, {24'd0, out8}, {24'd0, exp});
  endtask

  task automatic strobe16(input string tag, input logic [15:0] exp);
    req16 = 1'b1;
    step();
    req16 = 1'b0;
    check({tag, ".valid"}, {31'd0, valid16}, 32'd1);
    check({tag, ".data"}, {16'd0, out16}, {16'd0, exp});
    step(4);
  endtask

  logic [7:0] fwd [8];
  logic [7:0] bwd [8];

  initial begin
    fwd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    bwd = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

    #1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    check("rst.out", {24'd0, out8}, 32'd0);
    check("rst.valid_under", {30'd0, valid8, under8}, 32'd0);
    check("rst.busy_done", {30'd0, busy8, done8}, 32'd0);
    check("rst.read", {31'd0, rd8}, 32'd0);
    check("rst.addr", {9'd0, addr8}, 32'd0);

    // Forward loop through both words, then wrap back to word 0.
    rev8 = 1'b0;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    check("fwd.read_after_start", {31'd0, rd8}, 32'd1);
    check("fwd.busy", {31'd0, busy8}, 32'd1);
    step(4);
    for (int i = 0; i < 8; i++) begin
      strobe8($sformatf("fwd%0d", i), fwd[i]);
      if (i != 7) step(4);
    end
    check("fwd.wrap_read", {31'd0, rd8}, 32'd1);
    check("fwd.wrap_addr", {9'd0, addr8}, 32'd0);

    // Reverse, restarted while a read is being accepted.
    rev8 = 1'b1;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    check("rev.start_addr", {9'd0, addr8}, 32'd1);
    step(5);
    for (int i = 0; i < 8; i++) begin
      strobe8($sformatf("rev%0d", i), bwd[i]);
      if (i != 7) step(4);
    end
    check("rev.wrap_read", {31'd0, rd8}, 32'd1);
    check("rev.wrap_addr", {9'd0, addr8}, 32'd1);

    // Direction flips on the step after sample 22.
    rev8 = 1'b0;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(5);
    strobe8("tog0", 8'h11);
    step(4);
    rev8 = 1'b1;
    strobe8("tog1", 8'h22);
    step(4);
    strobe8("tog2", 8'h11);
    check("tog.wrap_read", {31'd0, rd8}, 32'd1);
    check("tog.wrap_addr", {9'd0, addr8}, 32'd1);

    // Stalled read: request held stable, strobe during the stall underruns.
    rev8 = 1'b0;
    wait8 = 1'b1;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req8 = 1'b1;
      step();
      req8 = 1'b0;
      check($sformatf("stall%0d.read", i), {31'd0, rd8}, 32'd1);
      check($sformatf("stall%0d.addr", i), {9'd0, addr8}, 32'd0);
      if (i == 2) begin
        check("stall.underrun", {31'd0, under8}, 32'd1);
        check("stall.no_valid", {31'd0, valid8}, 32'd0);
        check("stall.out_hold", {24'd0, out8}, 32'h11);
      end
    end
    wait8 = 1'b0;
    step(4);
    strobe8("stall.after", 8'h11);
    step(4);

    // Pause drops the strobe silently.
    pause8 = 1'b1;
    req8 = 1'b1;
    step();
    req8 = 1'b0;
    pause8 = 1'b0;
    check("pause.valid_under", {30'd0, valid8, under8}, 32'd0);
    strobe8("pause.next", 8'h22);
    step(4);

    // Reset mid WAIT_DATA, then a stale data beat.
    mute8 = 1'b1;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    check("rstwd.busy", {31'd0, busy8}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstwd.out", {24'd0, out8}, 32'd0);
    check("rstwd.flags", {28'd0, valid8, under8, busy8, done8}, 32'd0);
    check("rstwd.read_addr", {8'd0, rd8, addr8}, 32'd0);
    inj8 = 1'b1;
    step();
    inj8 = 1'b0;
    step();
    check("stale.busy", {31'd0, busy8}, 32'd0);
    check("stale.out", {25'd0, valid8, out8}, 32'd0);
    mute8 = 1'b0;
    rev8 = 1'b0;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(5);
    strobe8("restart", 8'h11);

    // 16-bit one-shot clip.
    start16 = 1'b1;
    step();
    start16 = 1'b0;
    check("w16.read", {31'd0, rd16}, 32'd1);
    step(5);
    strobe16("w16.s0", 16'hAAAA);
    check("w16.not_done", {31'd0, done16}, 32'd0);
    strobe16("w16.s1", 16'hBBBB);
    check("w16.done", {31'd0, done16}, 32'd1);
    check("w16.busy", {31'd0, busy16}, 32'd0);
    check("w16.no_read", {31'd0, rd16}, 32'd0);
    req16 = 1'b1;
    step();
    req16 = 1'b0;
    check("w16.idle_req", {30'd0, valid16, under16}, 32'd0);
    check("w16.idle_out", {16'd0, out16}, 32'hBBBB);
    start16 = 1'b1;
    step();
    start16 = 1'b0;
    check("w16.restart_done", {30'd0, done16, rd16}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/flash_sample_streamer.md
# flash_sample_streamer

Parametrised audio sample streamer between the Avalon-MM flash read port and the audio output path. It fetches 32-bit flash words one at a time and splits each into 8- or 16-bit samples. Samples are returned one per `sample_req` strobe, playing forward or in reverse through a bounded word region, with loop or one-shot end behaviour. It supersedes the byte-only fetcher by adding sample width, one-shot mode, a proper read handshake, start/pause control and underrun reporting.

## Interface
- `BASE`, 0, first flash word address of the clip.
- `MAX_OFFSET`, 16'h7FFF, offset of the last word of the clip; last word = `BASE+MAX_OFFSET`.
- `ADDR_W`, 23, flash word address width.
- `SAMPLE_W`, 8, sample width; legal values 8 or 16. `SPW = 32/SAMPLE_W` samples per word.
- `LOOP`, 1, 1 = wrap at clip end; 0 = stop and raise `done`.

Ports:
- `fetch_clock`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `flash_mem_waitrequest`  in  1  Avalon slave stall.
- `flash_mem_readdata`  in  32  read data.
- `flash_mem_readdatavalid`  in  1  read data qualifier.
- `flash_mem_read`  out  1  read request.
- `flash_mem_address`  out  ADDR_W  word address.
- `start`  in  1  pulse: (re)start playback from the clip end selected by `reverse`.
- `pause`  in  1  level: ignore `sample_req` while high.
- `reverse`  in  1  level: 0 forward, 1 reverse.
- `sample_req`  in  1  one-cycle sample strobe from the audio rate divider.
- `sample_out`  out  SAMPLE_W  current sample, held between updates.
- `sample_valid`  out  1  one-cycle pulse when `sample_out` updates.
- `underrun`  out  1  one-cycle pulse: `sample_req` arrived with no buffered word.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-shot end reached; cleared by `start` or `reset`.

## Operation
- Internal state:
  - `word_addr` (ADDR_W)
  - `idx` (log2 SPW bits)
  - `buf` (32-bit word buffer)
  - `buf_full` flag
  - FSM: IDLE, REQ, WAIT_DATA, SERVE.
- Reset:
  - FSM = IDLE, `word_addr` = BASE, `idx` = 0, `buf_full` = 0.
  - All outputs 0; `flash_mem_address` = BASE.
- Start:
  - `start` from any state aborts the current activity and goes to REQ.
  - Forward: `word_addr` = BASE, `idx` = 0. Reverse: `word_addr` = BASE+MAX_OFFSET, `idx` = SPW-1.
  - `buf_full` = 0, `done` = 0.
- IDLE: outputs hold; `sample_req` produces no `underrun`.
- REQ: assert `flash_mem_read` with `flash_mem_address` = `word_addr`. Hold both stable until a cycle with `waitrequest` = 0, then go to WAIT_DATA.
- WAIT_DATA: on `readdatavalid`, load `buf`, set `buf_full`, go to SERVE.
- SERVE, accepted `sample_req` (only when `pause` = 0 and `buf_full` = 1):
  - `sample_out` = `buf[idx*SAMPLE_W +: SAMPLE_W]`; `sample_valid` pulses.
  - Then step `idx`: +1 forward, -1 reverse.
- Word boundary: stepping past `SPW-1` (forward) or `0` (reverse) clears `buf_full`, moves `word_addr` by ±1, reloads `idx` with 0 (forward) or SPW-1 (reverse), and goes to REQ.
- Clip end:
  - Forward past BASE+MAX_OFFSET, or reverse below BASE: if LOOP, wrap to the opposite clip end and go to REQ.
  - If not LOOP: go to IDLE and set `done`.
- `reverse` is sampled on each step. A change mid-word takes effect on the next step from the current `idx`, with no refetch.
- `sample_req` in REQ or WAIT_DATA (with `pause` = 0): pulse `underrun`; `sample_out` holds.
- `readdatavalid` outside WAIT_DATA is ignored.
- `start` or `reset` during WAIT_DATA drops the pending read's data: the next `readdatavalid` after abort is discarded, and only one read is ever outstanding.

## Timing
- `start` at cycle T: `flash_mem_read` high at T+1.
- Read accepted at first edge with `waitrequest` = 0. Data latched the cycle `readdatavalid` is high; SERVE entered the next cycle.
- `sample_req` accepted at cycle T: `sample_out` and `sample_valid` registered at T+1 (one-cycle latency).
- Last sample of a word at T: `flash_mem_read` high at T+1.
- Zero-wait flash with readdatavalid one cycle after acceptance: refill takes 3 cycles. The audio strobe period must exceed 3 cycles.
- `start` and `sample_req` in the same cycle: `start` wins, and no `underrun` or `sample_valid` is produced.
- `pause` with `sample_req` in the same cycle: request dropped silently.

## Test plan
- Forward, SAMPLE_W=8, BASE=0, MAX_OFFSET=1; word0 = 0x44332211, word1 = 0x88776655. 8 strobes -> samples 11,22,33,44,55,66,77,88. Then, with LOOP=1, a read of address 0.
- Reverse, same data -> 88,77,66,55,44,33,22,11. Next read address = 1 (wrap).
- SAMPLE_W=16, LOOP=0, word0 = 0xBBBBAAAA -> AAAA, BBBB. At clip end: `done` = 1, `busy` = 0, no further reads.
- `waitrequest` held high 5 cycles: address and read stable throughout. A `sample_req` during the wait -> `underrun` pulse, `sample_out` unchanged.
- Toggle `reverse` after sample 22 of word 0x44332211 -> next samples 11, then fetch from wrapped address.
- `reset` mid-WAIT_DATA, then a stale `readdatavalid` -> ignored; all outputs 0; state IDLE.
